ysyx_23060236_icache_refill: RTL

Refill controller that writes the instruction cache's storage array. On a fetch miss it accepts the missing address and issues one AXI4 INCR read burst for the 32-byte line. It streams each returned beat into the array's write port (`icache_awaddr`/`icache_wdata`/`icache_wvalid`) and signals completion to the fetch stage. It sits between the IFU miss logic and the AXI crossbar toward SDRAM.

---
 rtl/ysyx_23060236_icache_refill.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ysyx_23060236_icache_refill.sv
// I-cache line refill: one AXI4 INCR burst of 8x32-bit beats per miss.
// Ports: miss req/ack, fence.i, array write port, AXI4 AR/R channels.
module ysyx_23060236_icache_refill #(
  parameter logic [6:0] ADDR_HI = 7'b1010000,
  parameter logic [3:0] AXI_ID  = 4'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [24:0] req_addr,
  input  logic        inst_fencei,
  output logic        refill_done,
  output logic        refill_err,
  output logic [24:0] icache_awaddr,
  output logic [31:0] icache_wdata,
  output logic        icache_wvalid,
  output logic        icache_inval,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] base_q, base_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [24:0] waddr_q, waddr_d;

  logic        req_fire;
  logic        beat_fire;
  logic        beat_bad;
  logic        wr_ok;
  logic        unused_addr_lo;

  // Line offset bits are irrelevant: the whole line is fetched.
  assign unused_addr_lo = ^req_addr[4:0];

  assign req_fire  = (state_q == S_IDLE) && req_valid;
  assign beat_fire = (state_q == S_R) && rvalid;

  // rlast must appear on beat 7 and only there.
  assign beat_bad = (rresp != 2'b00)
                  | (rid != AXI_ID)
                  | (rlast ^ (cnt_q == 3'd7));

  // A bad beat, or any beat once the line is doomed, is not written.
  assign wr_ok = beat_fire && !beat_bad && !err_q
              && !drop_q && !inst_fencei;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      waddr_q  <= waddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_AR;
      S_AR:   if (arready) state_d = S_R;
      S_R:    if (rvalid && rlast) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    base_d   = base_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    drop_d   = drop_q;
    wvalid_d = wr_ok;
    wdata_d  = wdata_q;
    waddr_d  = waddr_q;
    if (req_fire) begin
      base_d = req_addr[24:5];
      cnt_d  = '0;
      err_d  = 1'b0;
      drop_d = 1'b0;
    end
    if (beat_fire) begin
      cnt_d = cnt_q + 3'd1;
      if (beat_bad) err_d = 1'b1;
    end
    // The burst keeps running, but the line is abandoned.
    if ((state_q == S_AR || state_q == S_R) && inst_fencei)
      drop_d = 1'b1;
    if (wr_ok) begin
      wdata_d = rdata;
      waddr_d = {base_q, cnt_q, 2'b00};
    end
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE);
    arvalid       = (state_q == S_AR);
    araddr        = (state_q == S_AR) ? {ADDR_HI, base_q, 5'b0} : '0;
    arid          = AXI_ID;
    arlen         = 8'd7;
    arsize        = 3'b010;
    arburst       = 2'b01;
    rready        = (state_q == S_R);
    refill_done   = (state_q == S_DONE);
    refill_err    = (state_q == S_DONE) && err_q;
    icache_inval  = (state_q == S_DONE) && (err_q || drop_q);
    icache_wvalid = wvalid_q;
    icache_wdata  = wdata_q;
    icache_awaddr = waddr_q;
  end

endmodule
